// File: rtl/ring_buffer_pkg.sv
// Shared widths for the ring_buffer byte FIFO.
package ring_buffer_pkg;
    localparam int DATA_W  = 8;
    localparam int DEBUG_W = 32;
endpackage

// File: rtl/ring_buffer.sv
// Single-clock circular byte FIFO with registered read data, a one-cycle read ack
// and combinational pointer/occupancy debug words. One slot always stays empty.
module ring_buffer
    import ring_buffer_pkg::*;
#(
    parameter int BITLENGTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               writeEnable,
    input  logic [DATA_W-1:0]  data,
    input  logic               readEnable,
    output logic               dataReadAck,
    output logic [DATA_W-1:0]  dataRead,
    output logic [DEBUG_W-1:0] debug,
    output logic [DEBUG_W-1:0] debug2
);
    localparam int DEPTH = 1 << BITLENGTH;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [BITLENGTH-1:0] r_wr_ptr;
    logic [BITLENGTH-1:0] r_rd_ptr;
    logic [DATA_W-1:0]    r_data_read;
    logic                 r_data_read_ack;

    logic [BITLENGTH-1:0] w_wr_next;
    logic [BITLENGTH-1:0] w_rd_next;
    logic [BITLENGTH-1:0] w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;

    // Pointer arithmetic wraps naturally at BITLENGTH bits, so modulo depth is free.
    assign w_wr_next = r_wr_ptr + BITLENGTH'(1);
    assign w_rd_next = r_rd_ptr + BITLENGTH'(1);
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_wr_next == r_rd_ptr);
    assign w_push    = writeEnable && !w_full;
    assign w_pop     = readEnable && !w_empty;

    // NOTE: storage has no reset so it can map onto plain RAM; a stale slot is
    // never observable because the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // NOTE: non-blocking assignments here let the pop read the pre-edge slot
    // while a same-edge push updates a different one, independent of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_data_read     <= '0;
            r_data_read_ack <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr    <= w_rd_next;
                r_data_read <= r_mem[r_rd_ptr];
            end
            r_data_read_ack <= w_pop;
        end
    end

    assign dataRead    = r_data_read;
    assign dataReadAck = r_data_read_ack;
    assign debug       = {16'(r_rd_ptr), 16'(r_wr_ptr)};
    assign debug2      = DEBUG_W'(w_count);
endmodule

// File: tb/tb_ring_buffer.sv
// Directed bench for ring_buffer (BITLENGTH=2): queue-based reference model
// compared every falling edge, plus hand-computed literal expectations.
module tb_ring_buffer;
    localparam int BITLENGTH = 2;
    localparam int DEPTH     = 1 << BITLENGTH;
    localparam int CAP       = DEPTH - 1;

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [7:0]  data;
    logic        readEnable;
    logic        dataReadAck;
    logic [7:0]  dataRead;
    logic [31:0] debug;
    logic [31:0] debug2;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue plus totals of accepted pushes and pops.
    logic [7:0] m_q[$];
    int         m_wr_tot;
    int         m_rd_tot;
    logic [7:0] m_data;
    logic       m_ack;
    bit         cmp_en;

    ring_buffer #(.BITLENGTH(BITLENGTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (writeEnable),
        .data        (data),
        .readEnable  (readEnable),
        .dataReadAck (dataReadAck),
        .dataRead    (dataRead),
        .debug       (debug),
        .debug2      (debug2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wr_tot = 0;
        m_rd_tot = 0;
        m_data   = 8'h00;
        m_ack    = 1'b0;
    endtask

    function automatic logic [31:0] model_debug();
        return {16'(m_rd_tot % DEPTH), 16'(m_wr_tot % DEPTH)};
    endfunction

    // One clock: drive, take the edge, advance the model from the pre-edge state.
    task automatic cycle(input logic we, input logic [7:0] d, input logic re);
        bit was_full;
        bit was_empty;
        writeEnable = we;
        data        = d;
        readEnable  = re;
        @(posedge clk);
        was_full  = (m_q.size() == CAP);
        was_empty = (m_q.size() == 0);
        if (re && !was_empty) begin
            m_data = m_q.pop_front();
            m_ack  = 1'b1;
            m_rd_tot++;
        end else begin
            m_ack = 1'b0;
        end
        if (we && !was_full) begin
            m_q.push_back(d);
            m_wr_tot++;
        end
        #1;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ack",    32'(dataReadAck), 32'(m_ack));
            check("cmp_data",   32'(dataRead),    32'(m_data));
            check("cmp_debug",  debug,            model_debug());
            check("cmp_count",  debug2,           32'(m_q.size()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmp_en      = 1'b0;
        reset       = 1'b1;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        data        = 8'h00;
        model_reset();
        #22;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset then idle
        cycle(1'b0, 8'h00, 1'b0);
        check("idle_ack",   32'(dataReadAck), 32'h0);
        check("idle_data",  32'(dataRead),    32'h0);
        check("idle_debug", debug,            32'h0);
        check("idle_count", debug2,           32'h0);

        // Fill to capacity, then two reads
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        check("fill_count", debug2, 32'd3);
        check("fill_debug", debug,  32'h0000_0003);
        cycle(1'b0, 8'h00, 1'b1);
        check("rd1_data", 32'(dataRead),    32'h01);
        check("rd1_ack",  32'(dataReadAck), 32'h1);
        cycle(1'b0, 8'h00, 1'b1);
        check("rd2_data", 32'(dataRead),    32'h02);
        check("rd2_ack",  32'(dataReadAck), 32'h1);
        check("rd2_count", debug2, 32'd1);

        // Overfill from count 1: 0x08 is dropped
        cycle(1'b1, 8'h06, 1'b0);
        cycle(1'b1, 8'h07, 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        check("drop_count", debug2, 32'd3);
        check("drop_debug", debug,  32'h0002_0001);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain1", 32'(dataRead), 32'h03);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain2", 32'(dataRead), 32'h06);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain3", 32'(dataRead), 32'h07);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain4_ack",  32'(dataReadAck), 32'h0);
        check("drain4_data", 32'(dataRead),    32'h07);

        // Read while empty
        cycle(1'b0, 8'h00, 1'b1);
        check("empty_ack",   32'(dataReadAck), 32'h0);
        check("empty_data",  32'(dataRead),    32'h07);
        check("empty_debug", debug,            32'h0001_0001);

        // Wrap-around with alternating write/read pairs
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
            check("wrap_data", 32'(dataRead), 32'(8'h10 + i));
        end
        check("wrap_debug", debug, 32'h0003_0003);

        // Simultaneous read+write at empty: write wins, read fails
        cycle(1'b1, 8'hA0, 1'b1);
        check("rw_empty_ack",   32'(dataReadAck), 32'h0);
        check("rw_empty_count", debug2,           32'd1);
        // At count 1: old head returned, count unchanged
        cycle(1'b1, 8'hA1, 1'b1);
        check("rw_mid_data",  32'(dataRead), 32'hA0);
        check("rw_mid_count", debug2,        32'd1);
        // At full: read wins, write dropped
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        check("rw_full_data",  32'(dataRead), 32'hA1);
        check("rw_full_count", debug2,        32'd2);

        // Asynchronous reset mid-stream, checked before any clock edge
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_ack",   32'(dataReadAck), 32'h0);
        check("arst_data",  32'(dataRead),    32'h0);
        check("arst_debug", debug,            32'h0);
        check("arst_count", debug2,           32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Post-reset traffic works from a clean state
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_data", 32'(dataRead), 32'h5A);
        check("post_rst_debug", debug, 32'h0001_0001);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_buffer.md
Name: ring_buffer

Overview:
- Single-clock circular FIFO of 8-bit bytes with registered read data and a one-cycle read-acknowledge strobe.
- Storage depth is 2**BITLENGTH entries. One slot is always kept empty, so usable capacity is 2**BITLENGTH-1.
- Sits between a byte producer and a byte consumer.
- Exposes pointer and occupancy debug words for bring-up.

Parameters:
- BITLENGTH, default 2, pointer width in bits; storage depth = 2**BITLENGTH; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- writeEnable  input  1  request to push `data` on this rising edge.
- data  input  8  byte to write.
- readEnable  input  1  request to pop one byte on this rising edge.
- dataReadAck  output  1  registered; 1 for exactly the cycle after a successful pop.
- dataRead  output  8  registered; byte popped by the most recent successful read.
- debug  output  32  {16'(rdPtr), 16'(wrPtr)}, each zero-extended.
- debug2  output  32  current occupancy count, zero-extended.

Behaviour:
- State:
  - mem[2**BITLENGTH] x 8 bits.
  - wrPtr and rdPtr, BITLENGTH bits each, wrapping modulo 2**BITLENGTH.
  - dataRead and dataReadAck registers.
- Reset (asynchronous, while reset=1):
  - wrPtr=0, rdPtr=0, dataRead=0, dataReadAck=0.
  - mem contents are not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Status flags, combinational from the pre-edge pointers:
  - empty = (wrPtr == rdPtr).
  - full = (wrPtr+1 mod depth == rdPtr).
- Count = (wrPtr - rdPtr) mod depth, in the range 0..depth-1.
- Write on a rising edge:
  - If writeEnable && !full: mem[wrPtr] <= data, then wrPtr <= wrPtr+1 (wraps).
  - If full, the write is silently dropped: no pointer change, no error flag.
- Read on a rising edge:
  - If readEnable && !empty: dataRead <= mem[rdPtr], rdPtr <= rdPtr+1 (wraps), dataReadAck <= 1.
  - Otherwise dataReadAck <= 0 and dataRead holds its previous value.
- Latency: a byte read at edge N appears on dataRead and dataReadAck after edge N. A byte written at edge N is readable at edge N+1 at the earliest.
- Simultaneous read and write in one cycle:
  - Both are evaluated against the pre-edge full/empty flags.
  - If empty, the read fails and the write succeeds.
  - If full, the write fails and the read succeeds.
  - Otherwise both proceed and the count is unchanged.
- Data passes through unmodified. There is no arithmetic on data.
- debug and debug2 are combinational from the pointers.

Decomposition:
- Package ring_buffer_pkg holds DATA_W=8 and DEBUG_W=32.
- No sub-module is needed. The storage array is inferred inside the block.

Test Plan (BITLENGTH=2, capacity 3):
- Reset, then idle: dataReadAck=0, dataRead=0, debug=0, debug2=0.
- Write 0x01, 0x02, 0x03 on three edges: debug2=3 (full). Then read twice: dataRead=0x01 then 0x02, with ack high on each following cycle; debug2=1.
- From count 1, write 0x06, 0x07, 0x08: 0x06 and 0x07 are accepted and 0x08 is dropped (full). Then four reads return 0x03, 0x06, 0x07 with ack=1, followed by ack=0 with dataRead holding 0x07.
- Read when empty: dataReadAck=0, dataRead unchanged, rdPtr unchanged.
- Wrap-around: more than 8 alternating write/read pairs. Every byte returns in order, and debug pointers wrap 3->0.
- Simultaneous read+write at count 1: the read returns the old head, count stays 1. Assert reset mid-stream: outputs and pointers go to 0 immediately, without waiting for a clock edge.
